shape_drawer: RTL and testbench

Parametrised pixel generator that supersedes the fixed-size line drawer. It produces a stream of (x, y, colour) pixel writes toward the frame-buffer writer for three operations: Bresenham line in any octant, filled axis-aligned rectangle, and full-screen clear. Geometry and colour are configurable. The pixel output has a valid/ready handshake, so the downstream frame-buffer port may stall. Off-screen pixels are clipped internally.

---
 rtl/shape_drawer_if.sv | 15 +
 rtl/shape_drawer.sv | 207 ++++++++++++++++++++
 tb/tb_shape_drawer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/shape_drawer_if.sv
// Pixel write stream from the shape drawer toward the frame-buffer writer.
// The drawer is the master; the frame-buffer port may stall it with px_ready.
interface shape_drawer_if #(
    parameter int CW   = 11,
    parameter int COLW = 4
) ();
    logic            px_valid;
    logic            px_ready;
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic [COLW-1:0] colour;

    modport master (output px_valid, output x, output y, output colour, input px_ready);
    modport slave  (input px_valid, input x, input y, input colour, output px_ready);
endinterface

// File: rtl/shape_drawer.sv
// Pixel generator: Bresenham line, filled rectangle and screen clear, with
// internal clipping and a stallable valid/ready pixel stream.
module shape_drawer #(
    parameter int CW       = 11,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int COLW     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [CW-1:0]   x0,
    input  logic [CW-1:0]   y0,
    input  logic [CW-1:0]   x1,
    input  logic [CW-1:0]   y1,
    input  logic [COLW-1:0] colour_in,
    output logic            busy,
    output logic            done,
    shape_drawer_if.master  px
);

    localparam logic [1:0] MODE_LINE  = 2'd0;
    localparam logic [1:0] MODE_RECT  = 2'd1;
    localparam logic [1:0] MODE_CLEAR = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam logic [CW:0]   SW_LIM = (CW+1)'(SCREEN_W);
    localparam logic [CW:0]   SH_LIM = (CW+1)'(SCREEN_H);
    localparam logic [CW-1:0] SW_MAX = CW'(SCREEN_W - 1);
    localparam logic [CW-1:0] SH_MAX = CW'(SCREEN_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             mode_reg, mode_next;
    logic [CW-1:0]          ax_reg, ax_next, ay_reg, ay_next;
    logic [CW-1:0]          bx_reg, bx_next, by_reg, by_next;
    logic [COLW-1:0]        col_reg, col_next;
    logic [CW-1:0]          cx_reg, cx_next, cy_reg, cy_next;
    logic [CW-1:0]          xmin_reg, xmin_next, xmax_reg, xmax_next, ymax_reg, ymax_next;
    logic signed [CW:0]     dx_reg, dx_next, dy_reg, dy_next;
    logic signed [CW+1:0]   err_reg, err_next;
    logic                   sx_reg, sx_next, sy_reg, sy_next;

    logic [CW-1:0]          adx, ady, xlo, xhi, ylo, yhi;
    logic signed [CW+1:0]   dx_ext, dy_ext, err_step;
    logic signed [CW+2:0]   e2, dx_w, dy_w;
    logic                   step_x, step_y, on_screen, is_last, advance;

    assign xlo = (ax_reg <= bx_reg) ? ax_reg : bx_reg;
    assign xhi = (ax_reg <= bx_reg) ? bx_reg : ax_reg;
    assign ylo = (ay_reg <= by_reg) ? ay_reg : by_reg;
    assign yhi = (ay_reg <= by_reg) ? by_reg : ay_reg;
    assign adx = xhi - xlo;
    assign ady = yhi - ylo;

    // Error terms are explicitly sign-extended so every compare and add is
    // done at full width and cannot wrap for any CW-bit endpoints.
    assign dx_ext = {dx_reg[CW], dx_reg};
    assign dy_ext = {dy_reg[CW], dy_reg};
    assign dx_w   = {{2{dx_reg[CW]}}, dx_reg};
    assign dy_w   = {{2{dy_reg[CW]}}, dy_reg};
    assign e2     = {err_reg, 1'b0};
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);

    assign on_screen = ({1'b0, cx_reg} < SW_LIM) && ({1'b0, cy_reg} < SH_LIM);
    assign is_last   = (mode_reg == MODE_LINE) ? ((cx_reg == bx_reg) && (cy_reg == by_reg))
                                               : ((cx_reg == xmax_reg) && (cy_reg == ymax_reg));
    // Clipped candidates are consumed without waiting for the consumer.
    assign advance   = (state_reg == S_RUN) && (!on_screen || px.px_ready);

    assign px.px_valid = (state_reg == S_RUN) && on_screen;
    assign px.x        = cx_reg;
    assign px.y        = cy_reg;
    assign px.colour   = col_reg;
    assign busy        = (state_reg == S_INIT) || (state_reg == S_RUN);
    assign done        = (state_reg == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            mode_reg  <= '0;
            ax_reg    <= '0;
            ay_reg    <= '0;
            bx_reg    <= '0;
            by_reg    <= '0;
            col_reg   <= '0;
            cx_reg    <= '0;
            cy_reg    <= '0;
            xmin_reg  <= '0;
            xmax_reg  <= '0;
            ymax_reg  <= '0;
            dx_reg    <= '0;
            dy_reg    <= '0;
            err_reg   <= '0;
            sx_reg    <= 1'b0;
            sy_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            ax_reg    <= ax_next;
            ay_reg    <= ay_next;
            bx_reg    <= bx_next;
            by_reg    <= by_next;
            col_reg   <= col_next;
            cx_reg    <= cx_next;
            cy_reg    <= cy_next;
            xmin_reg  <= xmin_next;
            xmax_reg  <= xmax_next;
            ymax_reg  <= ymax_next;
            dx_reg    <= dx_next;
            dy_reg    <= dy_next;
            err_reg   <= err_next;
            sx_reg    <= sx_next;
            sy_reg    <= sy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        ax_next    = ax_reg;
        ay_next    = ay_reg;
        bx_next    = bx_reg;
        by_next    = by_reg;
        col_next   = col_reg;
        cx_next    = cx_reg;
        cy_next    = cy_reg;
        xmin_next  = xmin_reg;
        xmax_next  = xmax_reg;
        ymax_next  = ymax_reg;
        dx_next    = dx_reg;
        dy_next    = dy_reg;
        err_next   = err_reg;
        sx_next    = sx_reg;
        sy_next    = sy_reg;

        err_step = err_reg;
        if (step_x) err_step = err_step + dy_ext;
        if (step_y) err_step = err_step + dx_ext;

        case (state_reg)
            S_IDLE: begin
                if (start && (mode != MODE_RSVD)) begin
                    state_next = S_INIT;
                    mode_next  = mode;
                    ax_next    = x0;
                    ay_next    = y0;
                    bx_next    = x1;
                    by_next    = y1;
                    col_next   = (mode == MODE_CLEAR) ? '0 : colour_in;
                end
            end
            S_INIT: begin
                state_next = S_RUN;
                case (mode_reg)
                    MODE_LINE: begin
                        cx_next  = ax_reg;
                        cy_next  = ay_reg;
                        dx_next  = {1'b0, adx};
                        dy_next  = -{1'b0, ady};
                        err_next = {1'b0, 1'b0, adx} - {1'b0, 1'b0, ady};
                        sx_next  = (ax_reg > bx_reg);
                        sy_next  = (ay_reg > by_reg);
                    end
                    MODE_RECT: begin
                        cx_next   = xlo;
                        cy_next   = ylo;
                        xmin_next = xlo;
                        xmax_next = xhi;
                        ymax_next = yhi;
                    end
                    default: begin
                        cx_next   = '0;
                        cy_next   = '0;
                        xmin_next = '0;
                        xmax_next = SW_MAX;
                        ymax_next = SH_MAX;
                    end
                endcase
            end
            S_RUN: begin
                if (advance) begin
                    if (is_last) begin
                        state_next = S_DONE;
                    end else if (mode_reg == MODE_LINE) begin
                        err_next = err_step;
                        if (step_x) cx_next = sx_reg ? cx_reg - 1'b1 : cx_reg + 1'b1;
                        if (step_y) cy_next = sy_reg ? cy_reg - 1'b1 : cy_reg + 1'b1;
                    end else if (cx_reg == xmax_reg) begin
                        cx_next = xmin_reg;
                        cy_next = cy_reg + 1'b1;
                    end else begin
                        cx_next = cx_reg + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!start) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shape_drawer.sv
// Self-checking bench for shape_drawer: a default-size instance and a 4x2
// instance, checked against a plain-arithmetic pixel-list model.
module tb_shape_drawer;
    localparam int CW   = 11;
    localparam int COLW = 4;

    logic            clk = 1'b0;
    logic            reset, start, rdy;
    logic [1:0]      mode;
    logic [CW-1:0]   x0, y0, x1, y1;
    logic [COLW-1:0] colour_in;
    int              sel;
    logic            start_a, start_b;
    logic            busy0, done0, busy1, done1;

    logic            o_valid, o_busy, o_done;
    logic [CW-1:0]   o_x, o_y;
    logic [COLW-1:0] o_col;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [31:0]     exp_q[$];
    int              n_cand;

    always #5 clk = ~clk;

    shape_drawer_if #(.CW(CW), .COLW(COLW)) pa ();
    shape_drawer_if #(.CW(CW), .COLW(COLW)) pb ();

    assign pa.px_ready = rdy;
    assign pb.px_ready = rdy;
    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);

    shape_drawer #(.CW(CW), .SCREEN_W(320), .SCREEN_H(240), .COLW(COLW)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
        .busy(busy0), .done(done0), .px(pa.master)
    );

    shape_drawer #(.CW(CW), .SCREEN_W(4), .SCREEN_H(2), .COLW(COLW)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
        .busy(busy1), .done(done1), .px(pb.master)
    );

    always_comb begin
        if (sel == 0) begin
            o_valid = pa.px_valid; o_busy = busy0; o_done = done0;
            o_x = pa.x; o_y = pa.y; o_col = pa.colour;
        end else begin
            o_valid = pb.px_valid; o_busy = busy1; o_done = done1;
            o_x = pb.x; o_y = pb.y; o_col = pb.colour;
        end
    end

    function automatic logic [31:0] pk(input int px, input int py, input int pc);
        return 32'((px << 16) | (py << 4) | pc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected on-screen pixel list and total candidate count (including clipped).
    task automatic build(input int sel_i, input int m, input int ax, input int ay,
                         input int bx, input int by, input int col);
        int sw, sh, c, xa, xb, ya, yb;
        sw = (sel_i == 1) ? 4 : 320;
        sh = (sel_i == 1) ? 2 : 240;
        c  = (m == 2) ? 0 : col;
        exp_q.delete();
        n_cand = 0;
        if (m == 0) begin
            int dx, dy, sx, sy, err, cx, cy, e2;
            dx  = (bx > ax) ? bx - ax : ax - bx;
            dy  = -((by > ay) ? by - ay : ay - by);
            sx  = (ax < bx) ? 1 : -1;
            sy  = (ay < by) ? 1 : -1;
            err = dx + dy;
            cx  = ax;
            cy  = ay;
            while (1) begin
                n_cand++;
                if (cx < sw && cy < sh) exp_q.push_back(pk(cx, cy, c));
                if (cx == bx && cy == by) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; cx += sx; end
                if (e2 <= dx) begin err += dx; cy += sy; end
            end
        end else begin
            if (m == 1) begin
                xa = (ax < bx) ? ax : bx; xb = (ax < bx) ? bx : ax;
                ya = (ay < by) ? ay : by; yb = (ay < by) ? by : ay;
            end else begin
                xa = 0; xb = sw - 1; ya = 0; yb = sh - 1;
            end
            for (int yy = ya; yy <= yb; yy++)
                for (int xx = xa; xx <= xb; xx++) begin
                    n_cand++;
                    if (xx < sw && yy < sh) exp_q.push_back(pk(xx, yy, c));
                end
        end
    endtask

    // rpol: 0 always ready, 1 alternate 1,0,..., 2 random (also scrambles inputs)
    task automatic run_op(input int sel_i, input int m, input int ax, input int ay,
                          input int bx, input int by, input int col,
                          input int rpol, input int hold);
        int cyc, budget;
        logic got_done, prev_stall;
        logic [31:0] prev_pk, cur_pk, expv;
        build(sel_i, m, ax, ay, bx, by, col);
        @(negedge clk);
        sel = sel_i; mode = 2'(m);
        x0 = CW'(ax); y0 = CW'(ay); x1 = CW'(bx); y1 = CW'(by);
        colour_in = COLW'(col);
        start = 1'b1; rdy = 1'b1;
        cyc = 0; got_done = 1'b0; prev_stall = 1'b0; prev_pk = '0;
        budget = n_cand * 4 + 20;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            cur_pk = pk(int'(o_x), int'(o_y), int'(o_col));
            if (cyc == 1) check("init_state", {30'd0, o_busy, o_valid}, 32'd2);
            check("valid_done_excl", {31'd0, o_valid & o_done}, 32'd0);
            if (prev_stall) check("stall_hold", {o_valid, cur_pk[30:0]}, {1'b1, prev_pk[30:0]});
            if (o_done) begin got_done = 1'b1; break; end
            if (rpol == 0) rdy = 1'b1;
            else if (rpol == 1) rdy = (cyc % 2 == 0);
            else begin
                rdy = 1'($urandom_range(0, 1));
                mode = 2'($urandom); x0 = CW'($urandom); y1 = CW'($urandom);
                colour_in = COLW'($urandom);
            end
            if (o_valid && rdy) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check("pixel", cur_pk, expv);
            end
            prev_stall = o_valid && !rdy;
            prev_pk    = cur_pk;
        end
        check("done_seen", {31'd0, got_done}, 32'd1);
        check("all_pixels", 32'(exp_q.size()), 32'd0);
        if (rpol == 0) check("cycles", 32'(cyc), 32'(n_cand + 2));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("done_hold", {31'd0, o_done}, 32'd1);
        end
        start = 1'b0;
        @(negedge clk);
        check("back_idle", {30'd0, o_busy, o_done}, 32'd0);
        $display("op sel=%0d mode=%0d (%0d,%0d)->(%0d,%0d) col=%0d rpol=%0d cand=%0d cycles=%0d",
                 sel_i, m, ax, ay, bx, by, col, rpol, n_cand, cyc);
    endtask

    initial begin
        int ax, ay, bx, by;
        reset = 1'b1; start = 1'b0; rdy = 1'b0; sel = 0; mode = '0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour_in = '0;
        repeat (3) @(negedge clk);
        check("reset_a", {pa.px_valid, busy0, done0, pa.x, pa.y, pa.colour}, 32'd0);
        check("reset_b", {pb.px_valid, busy1, done1, pb.x, pb.y, pb.colour}, 32'd0);
        reset = 1'b0;

        run_op(0, 0, 0, 0, 5, 2, 3, 0, 0);
        run_op(0, 0, 3, 7, 3, 3, 6, 0, 0);
        run_op(0, 0, 9, 9, 9, 9, 1, 0, 0);
        run_op(0, 0, 0, 0, 3, 0, 2, 1, 0);
        run_op(0, 1, 2, 1, 0, 0, 5, 0, 0);
        run_op(1, 2, 0, 0, 0, 0, 7, 0, 3);
        run_op(1, 2, 0, 0, 0, 0, 9, 2, 0);
        run_op(0, 0, 318, 5, 322, 5, 4, 0, 0);
        run_op(0, 0, 0, 2047, 2047, 0, 9, 2, 0);
        run_op(0, 0, 2047, 2047, 0, 0, 12, 0, 0);

        for (int i = 0; i < 10; i++)
            run_op(0, 0, $urandom_range(0, 340), $urandom_range(0, 250),
                   $urandom_range(0, 340), $urandom_range(0, 250), $urandom_range(0, 15), 2, 0);
        for (int i = 0; i < 6; i++) begin
            ax = $urandom_range(0, 330); ay = $urandom_range(0, 245);
            bx = $urandom_range(ax > 6 ? ax - 6 : 0, ax + 6);
            by = $urandom_range(ay > 6 ? ay - 6 : 0, ay + 6);
            run_op(0, 1, ax, ay, bx, by, $urandom_range(0, 15), 2, 0);
        end

        // Reserved mode must not start anything.
        @(negedge clk);
        sel = 0; mode = 2'd3; start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rsvd_idle", {31'd0, o_busy}, 32'd0);
        end
        start = 1'b0;
        $display("op reserved mode ignored");

        // Reset in the middle of a line aborts it and nothing resumes.
        @(negedge clk);
        sel = 0; mode = 2'd0; x0 = '0; y0 = '0; x1 = CW'(100); y1 = '0;
        colour_in = 4'd3; start = 1'b1; rdy = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_valid", {31'd0, o_valid}, 32'd1);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst_abort", {o_valid, o_busy, o_done, o_x, o_y, o_col}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stay_idle", {30'd0, o_busy, o_valid}, 32'd0);
        $display("op reset mid-line");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
